// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle control path: FSM states, opcodes,
// instruction classes, one-hot ALU class codes and PC source encodings.
// Imported by mc_opdecode and mc_control.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Instruction class produced by the opcode decoder.
  typedef enum logic [3:0] {
    CLS_RTYPE   = 4'd0,
    CLS_LW      = 4'd1,
    CLS_SW      = 4'd2,
    CLS_ADDI    = 4'd3,
    CLS_SLTI    = 4'd4,
    CLS_BEQ     = 4'd5,
    CLS_BNE     = 4'd6,
    CLS_JMP     = 4'd7,
    CLS_HALT    = 4'd8,
    CLS_ILLEGAL = 4'd9
  } instr_cls_e;

  // Opcodes (R-type is the whole 00xxx block).
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b01001;
  localparam logic [4:0] OP_ADDI = 5'b01010;
  localparam logic [4:0] OP_SLTI = 5'b01011;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BNE  = 5'b10001;
  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11111;

  // One-hot ALU class seen by the ALU-control decoder.
  localparam logic [4:0] ALU_FUNCT = 5'b00001;
  localparam logic [4:0] ALU_ADD   = 5'b00010;
  localparam logic [4:0] ALU_SUB   = 5'b00100;
  localparam logic [4:0] ALU_SLT   = 5'b01000;
  localparam logic [4:0] ALU_CMP   = 5'b10000;

  // PC source select.
  localparam logic [1:0] PC_PLUS1  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_opdecode.sv
// Opcode-to-instruction-class decoder with an illegal-opcode flag.
// Latency: purely combinational. Backpressure: none.
// Ports: op_code_i (5-bit opcode), cls_o (instruction class), illegal_o (undefined opcode).
module mc_opdecode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] op_code_i,
  output instr_cls_e cls_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o     = CLS_ILLEGAL;
    illegal_o = 1'b0;
    casez (op_code_i)
      5'b00???: cls_o = CLS_RTYPE;
      OP_LW:    cls_o = CLS_LW;
      OP_SW:    cls_o = CLS_SW;
      OP_ADDI:  cls_o = CLS_ADDI;
      OP_SLTI:  cls_o = CLS_SLTI;
      OP_BEQ:   cls_o = CLS_BEQ;
      OP_BNE:   cls_o = CLS_BNE;
      OP_JMP:   cls_o = CLS_JMP;
      OP_HALT:  cls_o = CLS_HALT;
      default: begin
        cls_o     = CLS_ILLEGAL;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle sequencing controller: FETCH/DECODE/EXEC/MEM/WB/HALT plus retired-instruction counter.
// Latency: strobes are combinational from state/op_code/zero; 2..5 cycles per instruction with mem_ready high.
// Backpressure: FETCH and MEM hold mem_req (and mem_we) until mem_ready; mem_ready ignored elsewhere.
// Ports: clk/reset (sync, active-high); op_code, zero, mem_ready in; memory, PC, IR, ALU and
// register-file strobes out; illegal pulse, halted flag and retired count for observability.
module mc_control
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       op_code,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_b,
  output logic [4:0]       alu_code,
  output logic             reg_we,
  output logic             reg_dst_mem,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  instr_cls_e       cls;
  logic             dec_illegal;
  logic             retire;
  logic             br_taken;

  mc_opdecode u_opdecode (
    .op_code_i (op_code),
    .cls_o     (cls),
    .illegal_o (dec_illegal)
  );

  // BEQ branches on zero, BNE on not-zero.
  assign br_taken = (cls == CLS_BEQ) ? zero : ~zero;

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS1;
    alu_src_b    = 1'b0;
    alu_code     = ALU_ADD;
    reg_we       = 1'b0;
    reg_dst_mem  = 1'b0;
    illegal      = 1'b0;
    halted       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (cls)
          CLS_JMP: begin
            pc_we   = 1'b1;
            pc_src  = PC_JUMP;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CLS_HALT: begin
            retire  = 1'b1;
            state_d = ST_HALT;
          end
          CLS_ILLEGAL: begin
            illegal = dec_illegal;
            state_d = ST_FETCH;
          end
          default: state_d = ST_EXEC;
        endcase
      end

      ST_EXEC: begin
        case (cls)
          CLS_RTYPE: begin
            alu_code = ALU_FUNCT;
            state_d  = ST_WB;
          end
          CLS_LW, CLS_SW: begin
            alu_src_b = 1'b1;
            state_d   = ST_MEM;
          end
          CLS_ADDI: begin
            alu_src_b = 1'b1;
            state_d   = ST_WB;
          end
          CLS_SLTI: begin
            alu_code  = ALU_SLT;
            alu_src_b = 1'b1;
            state_d   = ST_WB;
          end
          CLS_BEQ, CLS_BNE: begin
            alu_code = ALU_CMP;
            pc_we    = br_taken;
            pc_src   = br_taken ? PC_BRANCH : PC_PLUS1;
            retire   = 1'b1;
            state_d  = ST_FETCH;
          end
          // JMP/HALT/illegal never reach EXEC; recover to FETCH if op_code glitches.
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == CLS_SW);
        if (mem_ready) begin
          if (cls == CLS_SW) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        reg_we      = 1'b1;
        reg_dst_mem = (cls == CLS_LW);
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end

      ST_HALT: halted = 1'b1;

      default: state_d = ST_FETCH;
    endcase

    // Reset silences every strobe in the same cycle, before the state register is cleared.
    if (reset) begin
      state_d      = ST_FETCH;
      retire       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = PC_PLUS1;
      alu_src_b    = 1'b0;
      alu_code     = ALU_ADD;
      reg_we       = 1'b0;
      reg_dst_mem  = 1'b0;
      illegal      = 1'b0;
      halted       = 1'b0;
    end
  end

  // Counter wraps naturally at 2^CNT_W.
  assign retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule
